// File: rtl/cpu_dbg_pkg.sv
// Shared types and constants for the CPU debug probe.
package cpu_dbg_pkg;

    localparam int unsigned DBG_OUT_W = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } probe_state_e;

    // Select-field width: clog2(n), never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_dbg_byte_sel.sv
// Combinational channel/byte extractor; any select outside the populated
// channels or bytes yields 0x00.
module cpu_dbg_byte_sel
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 16
) (
    input  logic [NUM_CH*CH_W-1:0]           data_i,
    input  logic [sel_width(NUM_CH)-1:0]     ch_sel_i,
    input  logic [sel_width(CH_W/8)-1:0]     byte_sel_i,
    output logic [DBG_OUT_W-1:0]             byte_o
);

    localparam int unsigned BYTES  = CH_W / 8;
    localparam int unsigned SEL_W  = sel_width(NUM_CH);
    localparam int unsigned BSEL_W = sel_width(BYTES);

    // Full decode so unmatched (out-of-range) selects fall through to zero.
    always_comb begin
        byte_o = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (ch_sel_i == SEL_W'(ch) && byte_sel_i == BSEL_W'(b)) begin
                    byte_o = data_i[ch*CH_W + b*DBG_OUT_W +: DBG_OUT_W];
                end
            end
        end
    end

endmodule

// File: rtl/cpu_debug_probe.sv
// CPU debug probe: live/snapshot byte observation plus a serial snapshot dump.
// Optional channel-0 trigger is enabled by defining PROBE_TRIGGER_EN.
module cpu_debug_probe
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH*CH_W-1:0]           ch_data,
    input  logic [sel_width(NUM_CH)-1:0]     ch_sel,
    input  logic [sel_width(CH_W/8)-1:0]     byte_sel,
    input  logic                             mode,
    input  logic                             capture,
    input  logic                             scan_start,
    input  logic [CH_W-1:0]                  trig_val,
    input  logic                             trig_clr,
    output logic [DBG_OUT_W-1:0]             dbg_out,
    output logic                             dbg_valid,
    output logic                             busy,
    output logic                             trig_hit
);

    localparam int unsigned BYTES = CH_W / 8;
    localparam int unsigned TOTAL = NUM_CH * BYTES;
    localparam int unsigned IDX_W = sel_width(TOTAL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    probe_state_e              state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_CH*CH_W-1:0]    snap_q, snap_d;
    logic [DBG_OUT_W-1:0]      dbg_out_q, dbg_out_d;
    logic                      dbg_valid_q, dbg_valid_d;
    logic                      trig_q, trig_d;
    logic                      trig_fire;

    logic [DBG_OUT_W-1:0]      live_byte;
    logic [DBG_OUT_W-1:0]      snap_byte;
    logic [DBG_OUT_W-1:0]      scan_byte;

    cpu_dbg_byte_sel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_live_sel (
        .data_i     (ch_data),
        .ch_sel_i   (ch_sel),
        .byte_sel_i (byte_sel),
        .byte_o     (live_byte)
    );

    cpu_dbg_byte_sel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_snap_sel (
        .data_i     (snap_q),
        .ch_sel_i   (ch_sel),
        .byte_sel_i (byte_sel),
        .byte_o     (snap_byte)
    );

    // Scan order is the snapshot's own byte order, so a flat byte index
    // works for any BYTES, including non-powers of two.
    always_comb begin
        scan_byte = '0;
        for (int unsigned i = 0; i < TOTAL; i++) begin
            if (idx_q == IDX_W'(i)) begin
                scan_byte = snap_q[i*DBG_OUT_W +: DBG_OUT_W];
            end
        end
    end

`ifdef PROBE_TRIGGER_EN
    // Sticky channel-0 trigger; clear wins over a same-cycle match and
    // suppresses that match's snapshot load as well.
    always_comb begin
        trig_d    = trig_q;
        trig_fire = 1'b0;
        if (trig_clr) begin
            trig_d = 1'b0;
        end else if (state_q == ST_IDLE && !trig_q &&
                     ch_data[CH_W-1:0] == trig_val) begin
            trig_d    = 1'b1;
            trig_fire = 1'b1;
        end
    end
`else
    logic unused_trig_inputs;
    assign unused_trig_inputs = ^{trig_val, trig_clr};
    assign trig_d    = 1'b0;
    assign trig_fire = 1'b0;
`endif

    // Next-state and output decode for the IDLE/SCAN controller.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        dbg_out_d   = dbg_out_q;
        dbg_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                dbg_out_d = mode ? snap_byte : live_byte;
                if (scan_start) begin
                    snap_d  = ch_data;
                    idx_d   = '0;
                    state_d = ST_SCAN;
                end else if (capture || trig_fire) begin
                    snap_d = ch_data;
                end
            end
            ST_SCAN: begin
                dbg_out_d   = scan_byte;
                dbg_valid_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            dbg_out_q   <= '0;
            dbg_valid_q <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            dbg_out_q   <= dbg_out_d;
            dbg_valid_q <= dbg_valid_d;
            trig_q      <= trig_d;
        end
    end

    assign dbg_out   = dbg_out_q;
    assign dbg_valid = dbg_valid_q;
    assign busy      = (state_q == ST_SCAN);
    assign trig_hit  = trig_q;

endmodule

// File: tb/tb_cpu_debug_probe.sv
// Directed self-checking bench for cpu_debug_probe (NUM_CH=4, CH_W=16), plus a
// NUM_CH=3/CH_W=24 instance where out-of-range selects are representable.
// Expectations follow PROBE_TRIGGER_EN when it is defined.
module tb_cpu_debug_probe;

`ifdef PROBE_TRIGGER_EN
    localparam bit TRIG_EN = 1'b1;
`else
    localparam bit TRIG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ch_data;
    logic [1:0]  ch_sel;
    logic        byte_sel;
    logic        mode, capture, scan_start, trig_clr;
    logic [15:0] trig_val;
    logic [7:0]  dbg_out;
    logic        dbg_valid, busy, trig_hit;

    logic [71:0] ch_data2;
    logic [1:0]  ch_sel2, byte_sel2;
    logic [7:0]  dbg_out2;
    logic        dbg_valid2, busy2, trig_hit2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cpu_debug_probe #(.NUM_CH(4), .CH_W(16)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_sel(ch_sel),
        .byte_sel(byte_sel), .mode(mode), .capture(capture),
        .scan_start(scan_start), .trig_val(trig_val), .trig_clr(trig_clr),
        .dbg_out(dbg_out), .dbg_valid(dbg_valid), .busy(busy),
        .trig_hit(trig_hit)
    );

    cpu_debug_probe #(.NUM_CH(3), .CH_W(24)) dut2 (
        .clk(clk), .rst(rst), .ch_data(ch_data2), .ch_sel(ch_sel2),
        .byte_sel(byte_sel2), .mode(1'b0), .capture(1'b0),
        .scan_start(1'b0), .trig_val(24'hFFFFFF), .trig_clr(1'b0),
        .dbg_out(dbg_out2), .dbg_valid(dbg_valid2), .busy(busy2),
        .trig_hit(trig_hit2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] exp_b [8];

    initial begin
        exp_b = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

        rst = 1'b1; ch_data = '0; ch_sel = '0; byte_sel = 1'b0; mode = 1'b0;
        capture = 1'b0; scan_start = 1'b0; trig_clr = 1'b0;
        trig_val = 16'hDEAD;
        ch_data2 = '0; ch_sel2 = '0; byte_sel2 = '0;

        // Reset held two cycles
        step(); step();
        check("rst_dbg_out", 32'(dbg_out), 32'h00);
        check("rst_valid", 32'(dbg_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_trig", 32'(trig_hit), 32'h0);
        rst = 1'b0;

        // Live path
        ch_data = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
        ch_sel = 2'd1; byte_sel = 1'b1;
        step();
        check("live_ch1_b1", 32'(dbg_out), 32'hBE);
        byte_sel = 1'b0;
        step();
        check("live_ch1_b0", 32'(dbg_out), 32'hEF);

        // Out-of-range selects on the 3x24 instance
        ch_data2 = {24'hC3C2C1, 24'hB3B2B1, 24'hA3A2A1};
        ch_sel2 = 2'd2; byte_sel2 = 2'd2;
        step();
        check("w24_ch2_b2", 32'(dbg_out2), 32'hC3);
        ch_sel2 = 2'd3;
        step();
        check("w24_ch_oor", 32'(dbg_out2), 32'h00);
        ch_sel2 = 2'd1; byte_sel2 = 2'd3;
        step();
        check("w24_byte_oor", 32'(dbg_out2), 32'h00);
        byte_sel2 = 2'd0;
        step();
        check("w24_ch1_b0", 32'(dbg_out2), 32'hB1);

        // Capture then snapshot readback
        ch_data = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
        capture = 1'b1;
        step();
        capture = 1'b0;
        ch_data = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        mode = 1'b1; ch_sel = 2'd2; byte_sel = 1'b0;
        step();
        check("snap_ch2_b0", 32'(dbg_out), 32'h34);
        byte_sel = 1'b1;
        step();
        check("snap_ch2_b1", 32'(dbg_out), 32'h12);
        mode = 1'b0;
        step();
        check("live_ch2_b1", 32'(dbg_out), 32'hFF);

        // Full scan, with a mid-scan scan_start/capture that must be ignored
        ch_data = {16'h7766, 16'h5544, 16'h3322, 16'h1100};
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        check("scan_enter_busy", 32'(busy), 32'h1);
        check("scan_enter_valid", 32'(dbg_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("scan_b%0d", i), 32'(dbg_out), 32'(exp_b[i]));
            check($sformatf("scan_v%0d", i), 32'(dbg_valid), 32'h1);
            check($sformatf("scan_busy%0d", i), 32'(busy), (i < 7) ? 32'h1 : 32'h0);
            if (i == 3) begin
                scan_start = 1'b1; capture = 1'b1;
                ch_data = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
            end
            if (i == 4) begin
                scan_start = 1'b0; capture = 1'b0;
            end
        end
        step();
        check("scan_done_valid", 32'(dbg_valid), 32'h0);
        check("scan_done_busy", 32'(busy), 32'h0);

        // Reset aborts a scan at the 4th byte
        ch_data = {16'h7766, 16'h5544, 16'h3322, 16'h1100};
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        step(); step(); step();
        check("abort_pre_b2", 32'(dbg_out), 32'h22);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", 32'(dbg_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_dbg_out", 32'(dbg_out), 32'h00);
        step();
        check("abort_stay_idle", 32'(dbg_valid), 32'h0);
        ch_data = {16'h7766, 16'h5544, 16'h3322, 16'h22AB};
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        step();
        check("restart_b0", 32'(dbg_out), 32'hAB);
        check("restart_v0", 32'(dbg_valid), 32'h1);
        step();
        check("restart_b1", 32'(dbg_out), 32'h22);
        for (int i = 0; i < 6; i++) step();
        check("restart_done", 32'(busy), 32'h0);

        // Trigger on channel 0
        trig_val = 16'h00AA;
        mode = 1'b1; ch_sel = 2'd1; byte_sel = 1'b0;
        ch_data = {16'h0000, 16'h0000, 16'h5A5A, 16'h00A9};
        step();
        check("trig_nomatch", 32'(trig_hit), 32'h0);
        ch_data = {16'h0000, 16'h0000, 16'h5A5A, 16'h00AA};
        step();
        check("trig_hit", 32'(trig_hit), TRIG_EN ? 32'h1 : 32'h0);
        ch_data = {16'h0000, 16'h0000, 16'h0000, 16'h00AA};
        step();
        check("trig_snap_b0", 32'(dbg_out), TRIG_EN ? 32'h5A : 32'h22);
        check("trig_sticky", 32'(trig_hit), TRIG_EN ? 32'h1 : 32'h0);
        byte_sel = 1'b1;
        step();
        check("trig_no_reload", 32'(dbg_out), TRIG_EN ? 32'h5A : 32'h33);
        trig_clr = 1'b1;
        step();
        check("trig_clr_prio", 32'(trig_hit), 32'h0);
        trig_clr = 1'b0;
        step();
        check("trig_rehit", 32'(trig_hit), TRIG_EN ? 32'h1 : 32'h0);
        ch_data = '0;
        trig_clr = 1'b1;
        step();
        trig_clr = 1'b0;
        check("trig_cleared", 32'(trig_hit), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
